// File: rtl/axi_ar_split_pkg.sv
// Shared AXI AR burst-splitter types and constants.
// The optional 4KB page limit in axi_ar_split_calc is enabled by defining AXI_AR_SPLIT_4K_EN.
package axi_ar_split_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam int PAGE_BYTES = 4096;

    // Beat count, 1..256.
    typedef logic [8:0] beat_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } ar_state_e;

endpackage

// File: rtl/axi_ar_split_calc.sv
// Combinational sub-burst sizing: beats, next address and last flag for the current remainder.
// Defining AXI_AR_SPLIT_4K_EN stops INCR sub-bursts at 4KB page boundaries.
module axi_ar_split_calc
    import axi_ar_split_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BEATS  = 16
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]            size_i,
    input  logic [1:0]            burst_i,
    input  beat_t                 rem_i,
    output beat_t                 beats_o,
    output logic [ADDR_WIDTH-1:0] addr_next_o,
    output logic                  last_o
);

    localparam beat_t MAX_BEATS_C = beat_t'(MAX_BEATS);

    logic [ADDR_WIDTH-1:0] size_mask;
    logic [ADDR_WIDTH-1:0] aligned;
    beat_t                 beats;
`ifdef AXI_AR_SPLIT_4K_EN
    logic [12:0]           page_bytes;
    logic [12:0]           page_beats;
`endif

    always_comb begin
        size_mask = (ADDR_WIDTH'(1) << size_i) - ADDR_WIDTH'(1);
        aligned   = addr_i & ~size_mask;
        beats     = rem_i;
`ifdef AXI_AR_SPLIT_4K_EN
        page_bytes = 13'(PAGE_BYTES) - {1'b0, aligned[11:0]};
        page_beats = page_bytes >> size_i;
`endif
        if (burst_i == AXI_BURST_INCR) begin
            if (beats > MAX_BEATS_C) begin
                beats = MAX_BEATS_C;
            end
`ifdef AXI_AR_SPLIT_4K_EN
            // page_beats is at least 1 because aligned is size-aligned.
            if (13'(beats) > page_beats) begin
                beats = beat_t'(page_beats);
            end
`endif
        end
        beats_o     = beats;
        addr_next_o = aligned + (ADDR_WIDTH'(beats) << size_i);
        last_o      = (beats == rem_i);
    end

endmodule

// File: rtl/axi_ar_burst_splitter.sv
// AXI read-address burst splitter: INCR bursts are reissued as sub-bursts of at most MAX_BEATS beats.
// Optional 4KB page limit on sub-bursts when AXI_AR_SPLIT_4K_EN is defined.
module axi_ar_burst_splitter
    import axi_ar_split_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int USER_WIDTH = 6,
    parameter int MAX_BEATS  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  slave_valid_i,
    input  logic [ADDR_WIDTH-1:0] slave_addr_i,
    input  logic [7:0]            slave_len_i,
    input  logic [2:0]            slave_size_i,
    input  logic [1:0]            slave_burst_i,
    input  logic [2:0]            slave_prot_i,
    input  logic [3:0]            slave_region_i,
    input  logic                  slave_lock_i,
    input  logic [3:0]            slave_cache_i,
    input  logic [3:0]            slave_qos_i,
    input  logic [ID_WIDTH-1:0]   slave_id_i,
    input  logic [USER_WIDTH-1:0] slave_user_i,
    output logic                  slave_ready_o,
    output logic                  master_valid_o,
    output logic [ADDR_WIDTH-1:0] master_addr_o,
    output logic [7:0]            master_len_o,
    output logic [2:0]            master_size_o,
    output logic [1:0]            master_burst_o,
    output logic [2:0]            master_prot_o,
    output logic [3:0]            master_region_o,
    output logic                  master_lock_o,
    output logic [3:0]            master_cache_o,
    output logic [3:0]            master_qos_o,
    output logic [ID_WIDTH-1:0]   master_id_o,
    output logic [USER_WIDTH-1:0] master_user_o,
    output logic                  master_last_o,
    input  logic                  master_ready_i
);

    ar_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    beat_t                 rem_q, rem_d;
    logic                  load;

    beat_t                 beats;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  last;

    axi_ar_split_calc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAX_BEATS  (MAX_BEATS)
    ) u_calc (
        .addr_i      (addr_q),
        .size_i      (master_size_o),
        .burst_i     (master_burst_o),
        .rem_i       (rem_q),
        .beats_o     (beats),
        .addr_next_o (addr_next),
        .last_o      (last)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (slave_valid_i) begin
                    load    = 1'b1;
                    addr_d  = slave_addr_i;
                    rem_d   = beat_t'(slave_len_i) + beat_t'(1);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (master_ready_i) begin
                    addr_d = addr_next;
                    rem_d  = rem_q - beats;
                    if (last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
        end
    end

    // Attribute copies only change when a new burst is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            master_size_o   <= '0;
            master_burst_o  <= '0;
            master_prot_o   <= '0;
            master_region_o <= '0;
            master_lock_o   <= 1'b0;
            master_cache_o  <= '0;
            master_qos_o    <= '0;
            master_id_o     <= '0;
            master_user_o   <= '0;
        end else if (load) begin
            master_size_o   <= slave_size_i;
            master_burst_o  <= slave_burst_i;
            master_prot_o   <= slave_prot_i;
            master_region_o <= slave_region_i;
            master_lock_o   <= slave_lock_i;
            master_cache_o  <= slave_cache_i;
            master_qos_o    <= slave_qos_i;
            master_id_o     <= slave_id_i;
            master_user_o   <= slave_user_i;
        end
    end

    assign slave_ready_o  = (state_q == IDLE);
    assign master_valid_o = (state_q == ISSUE);
    assign master_addr_o  = addr_q;
    // Length/last are derived from registers; gated so they read zero while idle.
    assign master_len_o   = master_valid_o ? 8'(beats - beat_t'(1)) : 8'd0;
    assign master_last_o  = master_valid_o & last;

endmodule

// File: tb/tb_axi_ar_burst_splitter.sv
// Directed self-checking bench for axi_ar_burst_splitter (MAX_BEATS=16).
// Expectations for the 4KB case follow AXI_AR_SPLIT_4K_EN.
module tb_axi_ar_burst_splitter;
    localparam int ID_WIDTH   = 4;
    localparam int ADDR_WIDTH = 32;
    localparam int USER_WIDTH = 6;

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b0;
    logic                  slave_valid_i = 1'b0;
    logic [ADDR_WIDTH-1:0] slave_addr_i = '0;
    logic [7:0]            slave_len_i = '0;
    logic [2:0]            slave_size_i = '0;
    logic [1:0]            slave_burst_i = '0;
    logic [2:0]            slave_prot_i = '0;
    logic [3:0]            slave_region_i = '0;
    logic                  slave_lock_i = 1'b0;
    logic [3:0]            slave_cache_i = '0;
    logic [3:0]            slave_qos_i = '0;
    logic [ID_WIDTH-1:0]   slave_id_i = '0;
    logic [USER_WIDTH-1:0] slave_user_i = '0;
    logic                  slave_ready_o;
    logic                  master_valid_o;
    logic [ADDR_WIDTH-1:0] master_addr_o;
    logic [7:0]            master_len_o;
    logic [2:0]            master_size_o;
    logic [1:0]            master_burst_o;
    logic [2:0]            master_prot_o;
    logic [3:0]            master_region_o;
    logic                  master_lock_o;
    logic [3:0]            master_cache_o;
    logic [3:0]            master_qos_o;
    logic [ID_WIDTH-1:0]   master_id_o;
    logic [USER_WIDTH-1:0] master_user_o;
    logic                  master_last_o;
    logic                  master_ready_i = 1'b1;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    axi_ar_burst_splitter #(
        .ID_WIDTH (ID_WIDTH), .ADDR_WIDTH (ADDR_WIDTH),
        .USER_WIDTH (USER_WIDTH), .MAX_BEATS (16)
    ) dut (
        .clk_i (clk_i), .rst_ni (rst_ni),
        .slave_valid_i (slave_valid_i), .slave_addr_i (slave_addr_i),
        .slave_len_i (slave_len_i), .slave_size_i (slave_size_i),
        .slave_burst_i (slave_burst_i), .slave_prot_i (slave_prot_i),
        .slave_region_i (slave_region_i), .slave_lock_i (slave_lock_i),
        .slave_cache_i (slave_cache_i), .slave_qos_i (slave_qos_i),
        .slave_id_i (slave_id_i), .slave_user_i (slave_user_i),
        .slave_ready_o (slave_ready_o),
        .master_valid_o (master_valid_o), .master_addr_o (master_addr_o),
        .master_len_o (master_len_o), .master_size_o (master_size_o),
        .master_burst_o (master_burst_o), .master_prot_o (master_prot_o),
        .master_region_o (master_region_o), .master_lock_o (master_lock_o),
        .master_cache_o (master_cache_o), .master_qos_o (master_qos_o),
        .master_id_o (master_id_o), .master_user_o (master_user_o),
        .master_last_o (master_last_o), .master_ready_i (master_ready_i)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one AR at a falling edge once the splitter is idle; accepted at the next rising edge.
    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        while (!slave_ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check_eq("send_ready", {63'd0, slave_ready_o}, 64'd1);
        slave_valid_i = 1'b1;
        slave_addr_i  = addr;
        slave_len_i   = len;
        slave_size_i  = size;
        slave_burst_i = burst;
        @(negedge clk_i);
        slave_valid_i = 1'b0;
        $display("AR  addr=0x%08h len=%0d size=%0d burst=%0d", addr, len, size, burst);
    endtask

    // Check the sub-burst presented now, then step past its handshake (master_ready_i assumed 1).
    task automatic expect_sub(input string tag, input logic [31:0] addr,
                              input logic [7:0] len, input logic last);
        int n = 0;
        while (!master_valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        $display("SUB %s addr=0x%08h len=%0d last=%0b", tag, master_addr_o, master_len_o, master_last_o);
        check_eq({tag, "_valid"}, {63'd0, master_valid_o}, 64'd1);
        check_eq({tag, "_addr"}, {32'd0, master_addr_o}, {32'd0, addr});
        check_eq({tag, "_len"}, {56'd0, master_len_o}, {56'd0, len});
        check_eq({tag, "_last"}, {63'd0, master_last_o}, {63'd0, last});
        check_eq({tag, "_sready"}, {63'd0, slave_ready_o}, 64'd0);
        @(negedge clk_i);
    endtask

    initial begin
        slave_prot_i = 3'd5; slave_region_i = 4'hA; slave_lock_i = 1'b1;
        slave_cache_i = 4'h3; slave_qos_i = 4'hC; slave_id_i = 4'h9; slave_user_i = 6'h2B;
        #1;
        check_eq("rst_valid", {63'd0, master_valid_o}, 64'd0);
        check_eq("rst_last", {63'd0, master_last_o}, 64'd0);
        check_eq("rst_addr", {32'd0, master_addr_o}, 64'd0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_eq("rst_sready", {63'd0, slave_ready_o}, 64'd1);

        // 1: INCR 64 beats -> four 16-beat sub-bursts
        send_ar(32'h1000, 8'd63, 3'd2, 2'b01);
        check_eq("t1_attr", {35'd0, master_prot_o, master_region_o, master_lock_o, master_cache_o,
                             master_qos_o, master_id_o, master_user_o, master_size_o, master_burst_o},
                 {35'd0, 3'd5, 4'hA, 1'b1, 4'h3, 4'hC, 4'h9, 6'h2B, 3'd2, 2'b01});
        expect_sub("t1a", 32'h1000, 8'd15, 1'b0);
        expect_sub("t1b", 32'h1040, 8'd15, 1'b0);
        expect_sub("t1c", 32'h1080, 8'd15, 1'b0);
        expect_sub("t1d", 32'h10C0, 8'd15, 1'b1);
        check_eq("t1_bubble_valid", {63'd0, master_valid_o}, 64'd0);
        check_eq("t1_bubble_sready", {63'd0, slave_ready_o}, 64'd1);

        // 2: FIXED passes unsplit
        send_ar(32'h2004, 8'd63, 3'd2, 2'b00);
        expect_sub("t2", 32'h2004, 8'd63, 1'b1);
        check_eq("t2_done", {63'd0, master_valid_o}, 64'd0);

        // WRAP passes unsplit
        send_ar(32'h8008, 8'd3, 3'd2, 2'b10);
        expect_sub("twrap", 32'h8008, 8'd3, 1'b1);

        // 3: 4KB crossing
        send_ar(32'h0FF0, 8'd7, 3'd2, 2'b01);
`ifdef AXI_AR_SPLIT_4K_EN
        expect_sub("t3a", 32'h0FF0, 8'd3, 1'b0);
        expect_sub("t3b", 32'h1000, 8'd3, 1'b1);
`else
        expect_sub("t3", 32'h0FF0, 8'd7, 1'b1);
`endif

        // 4: backpressure on first sub-burst
        master_ready_i = 1'b0;
        send_ar(32'h5000, 8'd31, 3'd2, 2'b01);
        for (int i = 0; i < 5; i++) begin
            check_eq("t4_hold_valid", {63'd0, master_valid_o}, 64'd1);
            check_eq("t4_hold_addr", {32'd0, master_addr_o}, 64'h5000);
            check_eq("t4_hold_len", {56'd0, master_len_o}, 64'd15);
            check_eq("t4_hold_last", {63'd0, master_last_o}, 64'd0);
            @(negedge clk_i);
        end
        master_ready_i = 1'b1;
        expect_sub("t4a", 32'h5000, 8'd15, 1'b0);
        expect_sub("t4b", 32'h5040, 8'd15, 1'b1);

        // 5: unaligned start address realigns after the first sub-burst
        send_ar(32'h3003, 8'd20, 3'd2, 2'b01);
        expect_sub("t5a", 32'h3003, 8'd15, 1'b0);
        expect_sub("t5b", 32'h3040, 8'd4, 1'b1);

        // 6: async reset during 2nd sub-burst
        send_ar(32'h6000, 8'd63, 3'd2, 2'b01);
        expect_sub("t6a", 32'h6000, 8'd15, 1'b0);
        #2 rst_ni = 1'b0;
        #1;
        check_eq("t6_rst_valid", {63'd0, master_valid_o}, 64'd0);
        check_eq("t6_rst_last", {63'd0, master_last_o}, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_eq("t6_sready", {63'd0, slave_ready_o}, 64'd1);
        check_eq("t6_idle_valid", {63'd0, master_valid_o}, 64'd0);
        send_ar(32'h7000, 8'd0, 3'd2, 2'b01);
        expect_sub("t6b", 32'h7000, 8'd0, 1'b1);
        check_eq("t6_done", {63'd0, master_valid_o}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
